// File: rtl/rf_scoreboard_pkg.sv
// Shared constants for the register-file scoreboard: register address width,
// register count, pending-counter width and the r0 test.
package rf_scoreboard_pkg;

   localparam int GR_ADDR_W = 5;
   localparam int SB_NREG   = 32;
   localparam int SB_CNT_W  = 2;

   // r0 is hard-wired to zero, so it never has a producer worth tracking
   function automatic logic is_tracked_reg(input logic [GR_ADDR_W-1:0] addr);
      return addr != '0;
   endfunction

endpackage

// File: rtl/rf_scoreboard_if.sv
// ID/WB side of the scoreboard: source reads, issue, writeback, flush and
// the stall/busy results fed back to decode.
interface rf_scoreboard_if
   import rf_scoreboard_pkg::*;
#(
   parameter int NREG = SB_NREG
);

   logic                 flush;
   logic [GR_ADDR_W-1:0] raddr1;
   logic                 rs1_used;
   logic [GR_ADDR_W-1:0] raddr2;
   logic                 rs2_used;
   logic                 issue_valid;
   logic                 issue_we;
   logic [GR_ADDR_W-1:0] issue_dest;
   logic                 wb_we;
   logic [GR_ADDR_W-1:0] wb_waddr;
   logic                 id_stall;
   logic [NREG-1:0]      busy_mask;

   modport master (
      output flush, raddr1, rs1_used, raddr2, rs2_used,
             issue_valid, issue_we, issue_dest, wb_we, wb_waddr,
      input  id_stall, busy_mask
   );

   modport slave (
      input  flush, raddr1, rs1_used, raddr2, rs2_used,
             issue_valid, issue_we, issue_dest, wb_we, wb_waddr,
      output id_stall, busy_mask
   );

endinterface

// File: rtl/rf_scoreboard_sb_counter.sv
// One per-register pending-writer counter: saturating up/down with a
// synchronous clear that wins over any increment or decrement.
module rf_scoreboard_sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear first, a simultaneous inc+dec cancels, otherwise step and hold at the limits
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !dec && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (dec && !inc && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Counter register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (reset || clr)
      !(inc && !dec && (cnt_q == '1)));

   a_no_underflow: assert property (@(posedge clk) disable iff (reset || clr)
      !(dec && !inc && (cnt_q == '0)));

endmodule

// File: rtl/rf_scoreboard.sv
// Register-file scoreboard: counts in-flight writers per register between ID
// and WB and stalls ID until every used source has been written back.
module rf_scoreboard
   import rf_scoreboard_pkg::*;
#(
   parameter int NREG  = SB_NREG,
   parameter int CNT_W = SB_CNT_W
) (
   input  logic           clk,
   input  logic           reset,
   rf_scoreboard_if.slave sb
);

   logic [CNT_W-1:0] cnt [NREG];
   logic             inc;
   logic             dec;
   logic             hz1;
   logic             hz2;
   logic             full;
   logic [NREG-1:0]  busy;

   // r0 has no counter; a constant zero slot keeps the lookups uniform
   assign cnt[0] = '0;

   // Decode issue and writeback into an increment and a decrement request
   always_comb begin
      inc = sb.issue_valid && sb.issue_we && is_tracked_reg(sb.issue_dest);
      dec = sb.wb_we && is_tracked_reg(sb.wb_waddr);
   end

   for (genvar i = 1; i < NREG; i++) begin : g_cnt
      rf_scoreboard_sb_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk   (clk),
         .reset (reset),
         .clr   (sb.flush),
         .inc   (inc && (sb.issue_dest == GR_ADDR_W'(i))),
         .dec   (dec && (sb.wb_waddr == GR_ADDR_W'(i))),
         .cnt   (cnt[i])
      );
   end

   // Hazards look only at stored counts, so a producer retiring this cycle still blocks its readers
   always_comb begin
      hz1  = sb.rs1_used && is_tracked_reg(sb.raddr1) && (cnt[sb.raddr1] != '0);
      hz2  = sb.rs2_used && is_tracked_reg(sb.raddr2) && (cnt[sb.raddr2] != '0);
      full = sb.issue_we && is_tracked_reg(sb.issue_dest) && (cnt[sb.issue_dest] == '1);
   end

   // One busy bit per register with a pending writer
   always_comb begin
      busy = '0;
      for (int r = 1; r < NREG; r++) begin
         busy[r] = cnt[r] != '0;
      end
   end

   assign sb.id_stall  = hz1 || hz2 || full;
   assign sb.busy_mask = busy;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Testbench for rf_scoreboard: a table of directed vectors with hand-derived
// expectations, a short hand sequence, then random legal traffic checked
// against a per-register pending-count model.
module tb_rf_scoreboard;

   localparam int MAXCNT = 3;

   typedef struct {
      logic       rst;
      logic       flush;
      logic [4:0] raddr1;
      logic       rs1_used;
      logic [4:0] raddr2;
      logic       rs2_used;
      logic       issue_valid;
      logic       issue_we;
      logic [4:0] issue_dest;
      logic       wb_we;
      logic [4:0] wb_waddr;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic        exp_stall;
      logic [31:0] exp_busy;
   } vec_t;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   int   pend [32];
   vec_t tbl [$];

   rf_scoreboard_if sbif ();

   rf_scoreboard dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sbif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic stim_t mkStim(input logic rst, input logic fl,
                                    input logic [4:0] r1, input logic u1,
                                    input logic [4:0] r2, input logic u2,
                                    input logic iv, input logic we, input logic [4:0] dst,
                                    input logic wwe, input logic [4:0] wa);
      stim_t s;
      s.rst = rst; s.flush = fl;
      s.raddr1 = r1; s.rs1_used = u1; s.raddr2 = r2; s.rs2_used = u2;
      s.issue_valid = iv; s.issue_we = we; s.issue_dest = dst;
      s.wb_we = wwe; s.wb_waddr = wa;
      return s;
   endfunction

   function automatic stim_t idle(input logic [4:0] r1, input logic u1);
      return mkStim(0, 0, r1, u1, 5'd0, 0, 0, 0, 5'd0, 0, 5'd0);
   endfunction

   // Stall as stated by the hazard rules, from the model's pending counts
   function automatic logic modelStall(input stim_t s);
      logic h1, h2, fl;
      h1 = s.rs1_used && (s.raddr1 != 0) && (pend[s.raddr1] > 0);
      h2 = s.rs2_used && (s.raddr2 != 0) && (pend[s.raddr2] > 0);
      fl = s.issue_we && (s.issue_dest != 0) && (pend[s.issue_dest] == MAXCNT);
      return h1 || h2 || fl;
   endfunction

   function automatic logic [31:0] modelBusy();
      logic [31:0] b;
      b = '0;
      for (int r = 1; r < 32; r++) b[r] = pend[r] > 0;
      return b;
   endfunction

   // Model state change at a clock edge
   task automatic modelEdge(input stim_t s);
      int ir, dr;
      if (s.rst || s.flush) begin
         for (int r = 0; r < 32; r++) pend[r] = 0;
      end else begin
         ir = (s.issue_valid && s.issue_we) ? int'(s.issue_dest) : 0;
         dr = s.wb_we ? int'(s.wb_waddr) : 0;
         if (!(ir != 0 && ir == dr)) begin
            if (ir != 0 && pend[ir] < MAXCNT) pend[ir]++;
            if (dr != 0 && pend[dr] > 0) pend[dr]--;
         end
      end
   endtask

   task automatic applyStimulus(input stim_t s);
      @(negedge clk);
      reset            = s.rst;
      sbif.flush       = s.flush;
      sbif.raddr1      = s.raddr1;
      sbif.rs1_used    = s.rs1_used;
      sbif.raddr2      = s.raddr2;
      sbif.rs2_used    = s.rs2_used;
      sbif.issue_valid = s.issue_valid;
      sbif.issue_we    = s.issue_we;
      sbif.issue_dest  = s.issue_dest;
      sbif.wb_we       = s.wb_we;
      sbif.wb_waddr    = s.wb_waddr;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic exp_stall, input logic [31:0] exp_busy);
      vectors++;
      if (sbif.id_stall !== exp_stall) begin
         miscompares++;
         $display("[TB] FAIL %s id_stall got %0b expected %0b", name, sbif.id_stall, exp_stall);
      end
      vectors++;
      if (sbif.busy_mask !== exp_busy) begin
         miscompares++;
         $display("[TB] FAIL %s busy_mask got %h expected %h", name, sbif.busy_mask, exp_busy);
      end
   endtask

   task automatic finishCycle(input stim_t s);
      @(posedge clk);
      modelEdge(s);
   endtask

   task automatic runCheck(input string name, input stim_t s, input logic es, input logic [31:0] eb);
      applyStimulus(s);
      checkOutput(name, es, eb);
      finishCycle(s);
   endtask

   task automatic doReset();
      stim_t s;
      s = mkStim(1, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 5'd0);
      for (int k = 0; k < 2; k++) begin
         applyStimulus(s);
         finishCycle(s);
      end
   endtask

   initial begin
      stim_t s;
      logic  es;
      int    live [$];
      vectors     = 0;
      miscompares = 0;
      for (int r = 0; r < 32; r++) pend[r] = 0;

      // reset then idle
      tbl.push_back('{idle(5'd5, 1), 0, 32'h0});
      // r3 issue, hazard, retire, release one cycle after the WB write
      tbl.push_back('{mkStim(0, 0, 5'd5, 1, 5'd0, 0, 1, 1, 5'd3, 0, 5'd0), 0, 32'h0});
      tbl.push_back('{idle(5'd3, 1), 1, 32'h8});
      tbl.push_back('{idle(5'd3, 1), 1, 32'h8});
      tbl.push_back('{mkStim(0, 0, 5'd3, 1, 5'd0, 0, 0, 0, 5'd0, 1, 5'd3), 1, 32'h8});
      tbl.push_back('{idle(5'd3, 1), 0, 32'h0});
      // r7: two issues, issue+retire same cycle, two retires
      tbl.push_back('{mkStim(0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd7, 0, 5'd0), 0, 32'h0});
      tbl.push_back('{mkStim(0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd7, 0, 5'd0), 0, 32'h80});
      tbl.push_back('{mkStim(0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd7, 1, 5'd7), 0, 32'h80});
      tbl.push_back('{mkStim(0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 1, 5'd7), 0, 32'h80});
      tbl.push_back('{mkStim(0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 1, 5'd7), 0, 32'h80});
      tbl.push_back('{idle(5'd7, 1), 0, 32'h0});
      // r9 saturation: destination guard with no sources used
      tbl.push_back('{mkStim(0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd9, 0, 5'd0), 0, 32'h0});
      tbl.push_back('{mkStim(0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd9, 0, 5'd0), 0, 32'h200});
      tbl.push_back('{mkStim(0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd9, 0, 5'd0), 0, 32'h200});
      tbl.push_back('{mkStim(0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 5'd9, 1, 5'd9), 1, 32'h200});
      tbl.push_back('{mkStim(0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 5'd9, 0, 5'd0), 0, 32'h200});
      tbl.push_back('{mkStim(0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 1, 5'd9), 0, 32'h200});
      tbl.push_back('{mkStim(0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 1, 5'd9), 0, 32'h200});
      tbl.push_back('{idle(5'd9, 1), 0, 32'h0});
      // r0 is never tracked
      tbl.push_back('{mkStim(0, 0, 5'd0, 1, 5'd0, 1, 1, 1, 5'd0, 1, 5'd0), 0, 32'h0});
      tbl.push_back('{mkStim(0, 0, 5'd0, 1, 5'd0, 1, 0, 1, 5'd0, 0, 5'd0), 0, 32'h0});
      // flush overrides a same-cycle issue
      tbl.push_back('{mkStim(0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd4, 0, 5'd0), 0, 32'h0});
      tbl.push_back('{mkStim(0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd12, 0, 5'd0), 0, 32'h10});
      tbl.push_back('{mkStim(0, 1, 5'd0, 0, 5'd12, 1, 1, 1, 5'd4, 0, 5'd0), 1, 32'h1010});
      tbl.push_back('{mkStim(0, 0, 5'd4, 1, 5'd12, 1, 0, 0, 5'd0, 0, 5'd0), 0, 32'h0});
      // reset mid-sequence
      tbl.push_back('{mkStim(0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd5, 0, 5'd0), 0, 32'h0});
      tbl.push_back('{mkStim(1, 0, 5'd0, 0, 5'd5, 1, 1, 1, 5'd6, 0, 5'd0), 1, 32'h20});
      tbl.push_back('{mkStim(0, 0, 5'd0, 0, 5'd5, 1, 0, 0, 5'd0, 0, 5'd0), 0, 32'h0});

      reset = 1'b1;
      doReset();
      for (int i = 0; i < tbl.size(); i++) begin
         runCheck($sformatf("vec%0d", i), tbl[i].s, tbl[i].exp_stall, tbl[i].exp_busy);
      end

      // Hand sequence: inc and dec on different registers in one cycle, port-2 hazard release
      doReset();
      runCheck("seq_iss2", mkStim(0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd2, 0, 5'd0), 0, 32'h0);
      runCheck("seq_iss1_ret2", mkStim(0, 0, 5'd0, 0, 5'd2, 1, 1, 1, 5'd1, 1, 5'd2), 1, 32'h4);
      runCheck("seq_ret1", mkStim(0, 0, 5'd2, 1, 5'd1, 1, 0, 0, 5'd0, 1, 5'd1), 1, 32'h2);
      runCheck("seq_free", mkStim(0, 0, 5'd2, 1, 5'd1, 1, 0, 0, 5'd0, 0, 5'd0), 0, 32'h0);

      // Random legal traffic against the pending-count model
      doReset();
      for (int c = 0; c < 600; c++) begin
         s = mkStim(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                    5'($urandom_range(0, 31)), 1'($urandom), 5'($urandom_range(0, 31)), 1'($urandom),
                    0, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 15)), 0, 5'd0);
         es = modelStall(s);
         s.issue_valid = !es && ($urandom_range(0, 2) != 0);
         live.delete();
         for (int r = 1; r < 32; r++) if (pend[r] > 0) live.push_back(r);
         if ($urandom_range(0, 9) == 0) begin
            s.wb_we = 1'b1; s.wb_waddr = 5'd0;
         end else if (live.size() > 0 && $urandom_range(0, 1) == 1) begin
            s.wb_we = 1'b1;
            s.wb_waddr = 5'(live[$urandom_range(0, live.size() - 1)]);
         end
         runCheck($sformatf("rnd%0d", c), s, es, modelBusy());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Tracks outstanding register-file writes between decode (ID) and writeback (WB) of the in-order 5-stage pipeline.
- ID consults it before reading regfile ports 1/2 and stalls while a source register has an older producer still in flight.
- WB reports each regfile write as it commits, so pending entries retire in the same cycle the regfile is written.
- No forwarding: operands are read only after the producer has written the regfile.

Parameters:
- NREG, 32, number of architectural registers; r0 is never tracked.
- CNT_W, 2, width of each per-register pending counter; the maximum in-flight writers per register is 2^CNT_W-1.

Ports:
- clk  input  1  pipeline clock, all state updates on posedge
- reset  input  1  synchronous, active-high; clears all counters
- flush  input  1  pipeline flush (exception/ertn); discards all in-flight writers
- raddr1  input  5  ID source register 1, same address as regfile raddr1
- rs1_used  input  1  instruction in ID really reads raddr1
- raddr2  input  5  ID source register 2
- rs2_used  input  1  instruction in ID really reads raddr2
- issue_valid  input  1  ID instruction leaves ID this cycle (ID valid & ready_go & EX allowin)
- issue_we  input  1  issuing instruction writes a GR
- issue_dest  input  5  destination register of the issuing instruction
- wb_we  input  1  WB writes regfile this cycle; identical to regfile we
- wb_waddr  input  5  WB destination; identical to regfile waddr
- id_stall  output  1  a used source has a pending producer, or the destination counter is saturated
- busy_mask  output  32  bit i = counter[i] != 0; bit 0 is always 0

Behaviour:
- State: cnt[1..NREG-1], each CNT_W bits. There is no cnt[0]. Both outputs are combinational from state plus the ID inputs.
- Reset (synchronous): all counters go to 0. On the cycle after reset, busy_mask=0 and id_stall=0 for any inputs.
- Source hazard:
  - hz1 = rs1_used & raddr1!=0 & cnt[raddr1]!=0; hz2 is defined the same way for port 2.
  - A producer retiring in the current cycle still counts as pending (regfile write lands at the edge; read is stale this cycle).
  - Result: a dependent instruction in ID proceeds exactly one cycle after the WB write cycle.
- Destination guard: full = issue_we & issue_dest!=0 & cnt[issue_dest]=={CNT_W{1'b1}}.
- Stall output: id_stall = hz1 | hz2 | full.
- Counter update per cycle, with inc = issue_valid & issue_we & issue_dest!=0 and dec = wb_we & wb_waddr!=0:
  - Writes to r0 never touch state.
  - Different registers: inc and dec each apply to their own register.
  - Same register with both inc and dec: the counter is unchanged.
  - inc on a saturated counter: the counter holds. This is a protocol violation (ID must not issue while id_stall); the sim assertion fires.
  - dec on a zero counter: the counter holds, and the sim assertion fires.
- Flush: all counters go to 0 on the next edge and override inc/dec in the same cycle. Flush has priority below reset.
- Latency: an issue at edge N is visible in busy_mask/id_stall from cycle N+1. A retire at edge N clears the entry from cycle N+1.
- busy_mask[0] is tied to 0. id_stall has no internal registers beyond the counters.

Decomposition:
- Shared header (mycpu.h): GR_ADDR_W=5, NREG, CNT_W, and a macro for the r0 check.
- Natural sub-module: sb_counter (one CNT_W saturating up/down counter with clear). Instantiate it NREG-1 times via generate; the top holds decode and hazard logic.

Test Plan:
- Reset then idle: raddr1=5, rs1_used=1 -> id_stall=0, busy_mask=0.
- Issue: issue r3 at edge 1; raddr1=3 -> id_stall=1 from cycle 2, busy_mask=32'h8. wb_we=1, wb_waddr=3 at edge 4 -> id_stall still 1 in cycle 4, 0 in cycle 5.
- Same-register issue and retire: issue r7 twice (cnt=2), then issue r7 and retire r7 in the same cycle -> cnt stays 2. Two more retires -> busy_mask[7]=0.
- Saturation: three issues to r9 -> issue_we=1, issue_dest=9 gives id_stall=1 even with rs1_used=rs2_used=0. One retire -> id_stall=0.
- r0 handling: issue_dest=0, wb_waddr=0, raddr1=0 with rs1_used=1 -> no state change, id_stall=0, busy_mask=0.
- Flush: r4 and r12 pending; flush=1 together with issue r4 -> next cycle busy_mask=0. Reset asserted mid-sequence -> busy_mask=0 next cycle.
